// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding and sizing helper.
package nibble_serial_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width: clog2 of the step count, never narrower than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder_slice.sv
// One 4-bit ripple-carry slice built from explicit full-adder gate equations.
module adder_slice_4bit
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that adds WIDTH-bit operands one nibble per clock, LSB first, on a single shared slice.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; both are pure state
  // decodes, and sum/cout hold steady for as long as out_valid waits on out_ready.

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] s_nib;
  logic               c_nib;
  logic               last_step;

  assign last_step = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Select the active nibble of each operand for the shared slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDX_W'(k)) begin
        a_nib = a_q[k*SLICE_W +: SLICE_W];
        b_nib = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  adder_slice_4bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDX_W'(k)) sum[k*SLICE_W +: SLICE_W] <= s_nib;
          end
          carry <= c_nib;
          // idx parks on the last step instead of wrapping.
          if (last_step) cout <= c_nib;
          else           idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized bench for the nibble-serial adder: 16-bit and 4-bit instances against an arithmetic model.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  // 4-bit instance
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0] a4, b4, sum4;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: the true (WIDTH+1)-bit sum of two unsigned operands and a carry.
  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return 5'(x) + 5'(y) + 5'(c);
  endfunction

  // One complete transaction on the 16-bit instance.
  // hold: cycles DONE is stalled; early: out_ready high from acceptance; poke: in_valid pulsed while DONE.
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input int hold, input bit early, input bit poke);
    logic [16:0] exp;
    int lat;
    @(negedge clk);
    check("pre_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    cin       = cv;
    out_ready = early;
    exp_q.push_back(model16(av, bv, cv));
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    check("latency", lat, 4);
    exp = exp_q.pop_front();
    check("sum", {16'b0, sum}, {16'b0, exp[15:0]});
    check("cout", cout, exp[16]);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        if (poke) begin
          in_valid = 1'b1;
          a        = 16'($urandom);
          b        = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_valid", out_valid, 1);
        check("hold_result", {cout, sum}, exp);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("result_kept", {cout, sum}, exp);
  endtask

  initial begin
    logic [4:0] exp4;
    int lat;
    int prev;
    int n_res;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    // Directed cases
    run_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_add(16'h0000, 16'h0000, 1'b1, 1, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b1, 1'b0);
    run_add(16'hA5A5, 16'h5A5A, 1'b1, 3, 1'b0, 1'b1);

    // Reset during the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1; a = 16'h8888; b = 16'h7777; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_add(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    // Random transactions
    for (int i = 0; i < 25; i++) begin
      run_add(16'($urandom), 16'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=4: single add, one-step latency
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    exp4 = model4(4'hF, 4'h1, 1'b0);
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w4_latency", lat, 1);
    check("w4_result", {cout4, sum4}, exp4);
    out_ready4 = 1'b1;
    @(negedge clk);
    check("w4_drop_valid", out_valid4, 0);

    // WIDTH=4 back-to-back with out_ready tied high: one result every 3 clocks
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    exp4 = model4(a4, b4, cin4);
    in_valid4 = 1'b1;
    prev = -1;
    n_res = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid4) begin
        n_res++;
        check("w4_b2b_result", {cout4, sum4}, exp4);
        if (prev >= 0) check("w4_b2b_interval", cyc - prev, 3);
        prev = cyc;
      end
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    check("w4_b2b_count", n_res >= 6, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
